// File: rtl/ex_alu_pipe.sv
// ---------------------------------------------------------------------------
// ex_alu_pipe
//   Handshaked execute stage sitting between decode and writeback. Accepts a
//   decoded op (operands + ALU opcode), computes the result, and holds it in a
//   single registered output slot together with the destination register and
//   a write enable. A persistent NZCV flag register is updated when an op that
//   asks for it lands in the slot. Opcode 3'b111 is an iterative shift-add
//   multiplier (one partial product per cycle) when MUL_EN=1, or a NOP when
//   MUL_EN=0, in which case no multiplier datapath is generated.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   op handshake from decode
//   alu_oc                000 NOP 001 ADD 010 SUB 011 AND 100 OR 101 XOR
//                         110 NOT 111 MUL
//   use_imm               operand B = immediate (1) or op_2 (0)
//   set_flags             update the flag register with this op
//   dest_reg              destination register address
//   op_1, op_2, immediate operand A, register operand B, immediate operand B
//   out_valid / out_ready result-slot handshake to writeback
//   out_result, out_dest  slot contents
//   out_wr_en             1 for every op except NOP
//   flags                 {N,Z,C,V}
//   dbg_state             current FSM state (IDLE=0, MUL=1, WAIT=2)
//
// Handshake semantics (both interfaces): a transfer happens at a rising edge
// where valid && ready are both high. A producer holding valid keeps its
// payload stable until the transfer; ready may depend combinationally on the
// consumer side (in_ready looks at out_ready) but never on in_valid.
// ---------------------------------------------------------------------------
module ex_alu_pipe #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_oc,
  input  logic              use_imm,
  input  logic              set_flags,
  input  logic [REG_W-1:0]  dest_reg,
  input  logic [DATA_W-1:0] op_1,
  input  logic [DATA_W-1:0] op_2,
  input  logic [DATA_W-1:0] immediate,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_dest,
  output logic              out_wr_en,
  output logic [3:0]        flags,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [2:0] OC_NOP = 3'b000;
  localparam logic [2:0] OC_ADD = 3'b001;
  localparam logic [2:0] OC_SUB = 3'b010;
  localparam logic [2:0] OC_AND = 3'b011;
  localparam logic [2:0] OC_OR  = 3'b100;
  localparam logic [2:0] OC_XOR = 3'b101;
  localparam logic [2:0] OC_NOT = 3'b110;
  localparam logic [2:0] OC_MUL = 3'b111;

  localparam int MSB   = DATA_W - 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  // Registers
  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_result;
  logic [REG_W-1:0]  r_out_dest;
  logic              r_out_wr_en;
  logic [3:0]        r_flags;
  logic [REG_W-1:0]  r_mul_dest;
  logic              r_mul_setf;

  // Wires
  logic              w_slot_free;
  logic              w_accept;
  logic              w_is_mul;
  logic              w_is_nop;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_c;
  logic              w_alu_v;
  logic [2*DATA_W-1:0] w_product;
  logic              w_wr;
  logic [DATA_W-1:0] w_wr_res;
  logic [REG_W-1:0]  w_wr_dest;
  logic              w_wr_en;
  logic              w_wr_upd;
  logic              w_wr_c;
  logic              w_wr_v;
  logic [3:0]        w_wr_flags;

  // The slot can take a new result if it is empty or is being drained at
  // this same edge.
  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = (r_state == S_IDLE) && w_slot_free;
  assign w_accept    = in_valid && in_ready;

  // With the multiplier disabled, 3'b111 decodes exactly like NOP.
  assign w_is_mul = MUL_EN && (alu_oc == OC_MUL);
  assign w_is_nop = (alu_oc == OC_NOP) || (!MUL_EN && (alu_oc == OC_MUL));

  assign w_b    = use_imm ? immediate : op_2;
  assign w_sum  = {1'b0, op_1} + {1'b0, w_b};
  // Bit DATA_W of the widened difference is the borrow.
  assign w_diff = {1'b0, op_1} - {1'b0, w_b};

  // Single-cycle ALU
  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (alu_oc)
      OC_ADD: begin
        w_alu_res = w_sum[MSB:0];
        w_alu_c   = w_sum[DATA_W];
        // Overflow: operands share a sign and the result sign differs.
        w_alu_v   = (op_1[MSB] == w_b[MSB]) && (w_sum[MSB] != op_1[MSB]);
      end
      OC_SUB: begin
        w_alu_res = w_diff[MSB:0];
        w_alu_c   = ~w_diff[DATA_W];
        // Overflow: operand signs differ and the result sign differs from A.
        w_alu_v   = (op_1[MSB] != w_b[MSB]) && (w_diff[MSB] != op_1[MSB]);
      end
      OC_AND: w_alu_res = op_1 & w_b;
      OC_OR:  w_alu_res = op_1 | w_b;
      OC_XOR: w_alu_res = op_1 ^ w_b;
      OC_NOT: w_alu_res = ~op_1;
      default: w_alu_res = '0;
    endcase
  end

  // Iterative multiplier: accumulator and multiplicand are double width so
  // the upper product half is available for the carry flag.
  generate
    if (MUL_EN) begin : g_mul
      logic [2*DATA_W-1:0] r_acc;
      logic [2*DATA_W-1:0] r_mcand;
      logic [DATA_W-1:0]   r_mplier;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_acc    <= '0;
          r_mcand  <= '0;
          r_mplier <= '0;
        end else if (w_accept && w_is_mul) begin
          // Every MUL starts from a cleared accumulator.
          r_acc    <= '0;
          r_mcand  <= {{DATA_W{1'b0}}, op_1};
          r_mplier <= w_b;
        end else if (r_state == S_MUL) begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
        end
      end

      assign w_product = r_acc;
    end else begin : g_no_mul
      assign w_product = '0;
    end
  endgenerate

  // Slot write source: a finished product in WAIT, or a non-MUL op accepted
  // in IDLE. The two cannot coincide because in_ready is low outside IDLE.
  always_comb begin
    w_wr      = 1'b0;
    w_wr_res  = '0;
    w_wr_dest = '0;
    w_wr_en   = 1'b0;
    w_wr_upd  = 1'b0;
    w_wr_c    = 1'b0;
    w_wr_v    = 1'b0;
    if ((r_state == S_WAIT) && w_slot_free) begin
      w_wr      = 1'b1;
      w_wr_res  = w_product[MSB:0];
      w_wr_dest = r_mul_dest;
      w_wr_en   = 1'b1;
      w_wr_upd  = r_mul_setf;
      w_wr_c    = |w_product[2*DATA_W-1:DATA_W];
      w_wr_v    = 1'b0;
    end else if (w_accept && !w_is_mul) begin
      w_wr      = 1'b1;
      w_wr_res  = w_alu_res;
      w_wr_dest = dest_reg;
      w_wr_en   = !w_is_nop;
      w_wr_upd  = set_flags && !w_is_nop;
      w_wr_c    = w_alu_c;
      w_wr_v    = w_alu_v;
    end
  end

  assign w_wr_flags = {w_wr_res[MSB], (w_wr_res == '0), w_wr_c, w_wr_v};

  // Output slot and flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_dest   <= '0;
      r_out_wr_en  <= 1'b0;
      r_flags      <= 4'b0000;
    end else begin
      if (w_wr) begin
        // A write while the old contents drain replaces the slot in place.
        r_out_valid  <= 1'b1;
        r_out_result <= w_wr_res;
        r_out_dest   <= w_wr_dest;
        r_out_wr_en  <= w_wr_en;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_wr && w_wr_upd) begin
        r_flags <= w_wr_flags;
      end
    end
  end

  // Control FSM; op attributes that must travel with a MUL are captured here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_mul_dest <= '0;
      r_mul_setf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mul) begin
            r_state    <= S_MUL;
            r_cnt      <= '0;
            r_mul_dest <= dest_reg;
            r_mul_setf <= set_flags;
          end
        end
        S_MUL: begin
          // DATA_W iterations: counts 0 .. DATA_W-1, then wraps to 0.
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (w_slot_free) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_dest   = r_out_dest;
  assign out_wr_en  = r_out_wr_en;
  assign flags      = r_flags;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_ex_alu_pipe.sv
`timescale 1ns/1ps
module tb_ex_alu_pipe;

  localparam int DW    = 16;
  localparam int RW    = 3;
  localparam int EXP_W = DW + RW + 1 + 4;
  localparam longint SMAX = (64'sd1 <<< (DW - 1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (DW - 1));

  localparam logic [2:0] NOP = 3'b000, ADD = 3'b001, SUB = 3'b010, AND_ = 3'b011;
  localparam logic [2:0] OR_ = 3'b100, XOR_ = 3'b101, NOT_ = 3'b110, MUL = 3'b111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT (MUL_EN=1) ----------------
  logic          in_valid, in_ready, use_imm, set_flags, out_valid, out_ready, out_wr_en;
  logic [2:0]    alu_oc;
  logic [RW-1:0] dest_reg, out_dest;
  logic [DW-1:0] op_1, op_2, immediate, out_result;
  logic [3:0]    flags;
  logic [1:0]    dbg_state;

  ex_alu_pipe #(.DATA_W(DW), .REG_W(RW), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_oc(alu_oc), .use_imm(use_imm), .set_flags(set_flags), .dest_reg(dest_reg),
    .op_1(op_1), .op_2(op_2), .immediate(immediate),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dest(out_dest), .out_wr_en(out_wr_en), .flags(flags), .dbg_state(dbg_state)
  );

  // ---------------- second instance (MUL_EN=0) ----------------
  logic          nm_in_valid, nm_in_ready, nm_use_imm, nm_set_flags, nm_out_valid, nm_out_ready, nm_out_wr_en;
  logic [2:0]    nm_alu_oc;
  logic [RW-1:0] nm_dest_reg, nm_out_dest;
  logic [DW-1:0] nm_op_1, nm_op_2, nm_immediate, nm_out_result;
  logic [3:0]    nm_flags;
  logic [1:0]    nm_dbg_state;

  ex_alu_pipe #(.DATA_W(DW), .REG_W(RW), .MUL_EN(1'b0)) u_nm (
    .clk(clk), .rst(rst), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
    .alu_oc(nm_alu_oc), .use_imm(nm_use_imm), .set_flags(nm_set_flags), .dest_reg(nm_dest_reg),
    .op_1(nm_op_1), .op_2(nm_op_2), .immediate(nm_immediate),
    .out_valid(nm_out_valid), .out_ready(nm_out_ready), .out_result(nm_out_result),
    .out_dest(nm_out_dest), .out_wr_en(nm_out_wr_en), .flags(nm_flags), .dbg_state(nm_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [3:0] model_flags = 4'b0000;
  logic rdy_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference model: plain arithmetic on wide integers.
  // Returns {result, dest, wr_en, flags-after-op}.
  function automatic logic [EXP_W-1:0] model(input logic [2:0] oc, input logic setf,
                                             input logic [RW-1:0] d, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b, input logic [3:0] fl_in);
    longint ua, ub, sa, sb, full, sfull;
    logic [DW-1:0] r;
    logic c, v, wr;
    logic [3:0] fl;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    full = 0; sfull = 0; r = '0; c = 1'b0; v = 1'b0; wr = 1'b1;
    case (oc)
      ADD: begin
        full = ua + ub; sfull = sa + sb; r = full[DW-1:0];
        c = (full >> DW) != 0; v = (sfull > SMAX) || (sfull < SMIN);
      end
      SUB: begin
        full = ua - ub; sfull = sa - sb; r = full[DW-1:0];
        c = (ua >= ub); v = (sfull > SMAX) || (sfull < SMIN);
      end
      AND_: r = a & b;
      OR_:  r = a | b;
      XOR_: r = a ^ b;
      NOT_: r = ~a;
      MUL: begin
        full = ua * ub; r = full[DW-1:0]; c = (full >> DW) != 0;
      end
      default: wr = 1'b0;
    endcase
    fl = (setf && wr) ? {r[DW-1], (r == '0), c, v} : fl_in;
    return {r, d, wr, fl};
  endfunction

  // ---------------- random out_ready driver ----------------
  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor ----------------
  logic stall_prev = 1'b0;
  logic [EXP_W:0] snap;
  logic [EXP_W-1:0] exp_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev)
        check("stall_hold", {out_valid, out_result, out_dest, out_wr_en, flags}, snap);
      if (out_valid && !out_ready)
        check("stall_in_ready", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output: got result 0x%0h with no expected entry", out_result);
        end else begin
          exp_e = exp_q.pop_front();
          check("slot", {out_result, out_dest, out_wr_en, flags}, exp_e);
        end
      end
      stall_prev = out_valid && !out_ready;
      snap = {out_valid, out_result, out_dest, out_wr_en, flags};
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [2:0] oc, input logic imm_sel, input logic setf,
                       input logic [RW-1:0] d, input logic [DW-1:0] a,
                       input logic [DW-1:0] o2, input logic [DW-1:0] im);
    logic acc;
    int waits;
    logic [DW-1:0] b;
    logic [EXP_W-1:0] e;
    alu_oc = oc; use_imm = imm_sel; set_flags = setf; dest_reg = d;
    op_1 = a; op_2 = o2; immediate = im; in_valid = 1'b1;
    acc = 1'b0; waits = 0;
    while (!acc && waits < 400) begin
      @(negedge clk);
      acc = in_ready && !rst;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: op %0d not accepted, expected acceptance within 400 cycles", oc);
    end else begin
      b = imm_sel ? im : o2;
      e = model(oc, setf, d, a, b, model_flags);
      model_flags = e[3:0];
      exp_q.push_back(e);
    end
  endtask

  task automatic nm_issue(input logic [2:0] oc, input logic setf,
                          input logic [DW-1:0] a, input logic [DW-1:0] o2);
    nm_alu_oc = oc; nm_set_flags = setf; nm_use_imm = 1'b0; nm_dest_reg = 3'd5;
    nm_op_1 = a; nm_op_2 = o2; nm_immediate = '0; nm_in_valid = 1'b1;
    @(negedge clk);
    check("nm_in_ready", nm_in_ready, 1'b1);
    @(posedge clk);
    #1;
    nm_in_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b0, {(DW-1){1'b1}}};
      3: return {1'b1, {(DW-1){1'b0}}};
      default: return DW'($urandom);
    endcase
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 ns");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, t0, bud;
    in_valid = 1'b0; alu_oc = NOP; use_imm = 1'b0; set_flags = 1'b0; dest_reg = '0;
    op_1 = '0; op_2 = '0; immediate = '0; out_ready = 1'b1;
    nm_in_valid = 1'b0; nm_alu_oc = NOP; nm_use_imm = 1'b0; nm_set_flags = 1'b0;
    nm_dest_reg = '0; nm_op_1 = '0; nm_op_2 = '0; nm_immediate = '0; nm_out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_result", out_result, 16'h0000);
    check("reset_out_dest", out_dest, 3'd0);
    check("reset_out_wr_en", out_wr_en, 1'b0);
    check("reset_flags", flags, 4'b0000);
    check("reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // ADD overflow into the sign bit
    issue(ADD, 1'b0, 1'b1, 3'd1, 16'h7FFF, 16'h0001, 16'h0000);
    check("add_valid_1cycle", out_valid, 1'b1);
    check("add_result", out_result, 16'h8000);
    check("add_flags", flags, 4'b1001);
    check("add_wr_en", out_wr_en, 1'b1);

    // SUB with immediate to zero, then XOR without flag update
    issue(SUB, 1'b1, 1'b1, 3'd2, 16'h0005, 16'h1234, 16'h0005);
    check("sub_result", out_result, 16'h0000);
    check("sub_flags", flags, 4'b0110);
    issue(XOR_, 1'b0, 1'b0, 3'd3, 16'hA5A5, 16'h0F0F, 16'h0000);
    check("xor_result", out_result, 16'hAAAA);
    check("xor_flags_hold", flags, 4'b0110);

    // MUL latency
    issue(MUL, 1'b0, 1'b1, 3'd4, 16'h0012, 16'h0034, 16'h0000);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (in_ready) break;
      lat++;
    end
    check("mul_in_ready_low_cycles", lat, 17);
    check("mul_out_valid", out_valid, 1'b1);
    check("mul_result", out_result, 16'h03A8);
    check("mul_flag_c", flags[1], 1'b0);
    @(posedge clk); #1;

    // MUL with nonzero upper half and zero low half
    issue(MUL, 1'b0, 1'b1, 3'd6, 16'h1000, 16'h0010, 16'h0000);
    bud = 0;
    while (bud < 40) begin
      @(negedge clk);
      if (out_valid) break;
      bud++;
    end
    check("mul_zero_result", out_result, 16'h0000);
    check("mul_zero_flags", flags, 4'b0110);
    @(posedge clk); #1;

    // Back-pressure: ADD held in the slot while OR waits
    out_ready = 1'b0;
    fork
      begin
        issue(ADD, 1'b0, 1'b0, 3'd1, 16'h1111, 16'h2222, 16'h0000);
        issue(OR_, 1'b0, 1'b1, 3'd2, 16'hF000, 16'h000F, 16'h0000);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_held_result", out_result, 16'h3333);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    check("bp_or_result", out_result, 16'hF00F);

    // Throughput with out_ready held high
    t0 = cyc;
    for (int i = 0; i < 8; i++)
      issue(3'($urandom_range(1, 6)), 1'($urandom), 1'($urandom), 3'($urandom), pick_operand(), pick_operand(), pick_operand());
    check("throughput_cycles", cyc - t0, 8);

    // MUL_EN=0 instance: 3'b111 is a single-cycle NOP
    nm_issue(ADD, 1'b1, 16'h7FFF, 16'h0001);
    check("nm_add_flags", nm_flags, 4'b1001);
    nm_issue(MUL, 1'b1, 16'h1000, 16'h0010);
    check("nm_mul_valid", nm_out_valid, 1'b1);
    check("nm_mul_wr_en", nm_out_wr_en, 1'b0);
    check("nm_mul_result", nm_out_result, 16'h0000);
    check("nm_mul_flags_hold", nm_flags, 4'b1001);

    // Asynchronous reset during the 5th MUL iteration
    issue(ADD, 1'b0, 1'b1, 3'd1, 16'h7FFF, 16'h0001, 16'h0000);
    issue(MUL, 1'b0, 1'b1, 3'd7, 16'h00FF, 16'h0101, 16'h0000);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_flags", flags, 4'b0000);
    check("rst_out_result", out_result, 16'h0000);
    exp_q.delete();
    model_flags = 4'b0000;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    issue(ADD, 1'b0, 1'b0, 3'd2, 16'h0002, 16'h0003, 16'h0000);
    check("post_rst_add_valid", out_valid, 1'b1);
    check("post_rst_add_result", out_result, 16'h0005);

    // Randomized traffic with random back-pressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 120; i++)
      issue(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 3'($urandom), pick_operand(), pick_operand(), pick_operand());

    bud = 0;
    while (exp_q.size() != 0 && bud < 1000) begin
      @(posedge clk);
      bud++;
    end
    rdy_rand = 1'b0;
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
